// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus initiator: FSM state encoding and bus cycle types.
package z80_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_TA,
    ST_TW,
    ST_T3
  } state_t;

  // Bit 1 selects I/O space, bit 0 selects write.
  typedef enum logic [1:0] {
    MEM_RD = 2'b00,
    MEM_WR = 2'b01,
    IO_RD  = 2'b10,
    IO_WR  = 2'b11
  } cyc_t;

  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

  function automatic logic cyc_is_io(cyc_t c);
    return c[1];
  endfunction

  function automatic logic cyc_is_wr(cyc_t c);
    return c[0];
  endfunction

endpackage

// File: rtl/z80_bus_initiator_if.sv
// Request/response handshake and Z80 bus pins of the bus initiator.
interface z80_bus_initiator_if;
  logic        i_req_valid;
  logic        i_req_wr;
  logic        i_req_io;
  logic [15:0] i_req_addr;
  logic [7:0]  i_req_wdata;
  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [7:0]  o_rsp_rdata;
  logic        o_rsp_err;
  logic [15:0] o_addr;
  logic [7:0]  o_data;
  logic        o_data_oe;
  logic        o_mreq_n;
  logic        o_iorq_n;
  logic        o_rd_n;
  logic        o_wr_n;
  logic        i_wait;
  logic [7:0]  i_data;

  modport master (
    input  i_req_valid, i_req_wr, i_req_io, i_req_addr, i_req_wdata, i_wait, i_data,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_addr, o_data, o_data_oe, o_mreq_n, o_iorq_n, o_rd_n, o_wr_n
  );

  modport slave (
    output i_req_valid, i_req_wr, i_req_io, i_req_addr, i_req_wdata, i_wait, i_data,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_addr, o_data, o_data_oe, o_mreq_n, o_iorq_n, o_rd_n, o_wr_n
  );
endinterface

// File: rtl/z80_bus_wait_watchdog.sv
// Counts consecutive TW states; flags the TW state in which the wait limit is reached.
module z80_bus_wait_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_in_tw,
  output logic o_expired
);
  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Down-counter is preloaded outside TW so the first TW already sees LOAD.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_in_tw) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_in_tw && (cnt_q == '0);
endmodule

// File: rtl/z80_bus_initiator.sv
// Z80 bus cycle initiator: runs one memory or I/O read/write per accepted request.
// Optional wait timeout enabled by defining Z80_BUS_INITIATOR_WAIT_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for request; also the response cycle after T3
// T1    | address out, memory strobes start
// T2    | I/O strobes start; memory wait sample point
// TA    | automatic I/O wait; last TA is the I/O wait sample point
// TW    | extended wait while peripheral holds i_wait
// T3    | final bus state; read data captured on exit
module z80_bus_initiator
  import z80_bus_pkg::*;
#(
  parameter int IO_AUTO_WAIT   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  i_clk,
  input logic                  i_reset,
  z80_bus_initiator_if.master  bus
);
  if (IO_AUTO_WAIT < 0 || IO_AUTO_WAIT > 3) begin : g_bad_auto_wait
    $error("IO_AUTO_WAIT must be within 0..3");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [1:0] TA_LOAD = (IO_AUTO_WAIT > 0) ? 2'(IO_AUTO_WAIT - 1) : 2'd0;

  state_t      state_q, state_d;
  cyc_t        cyc_q, cyc_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  ta_cnt_q, ta_cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;

`ifdef Z80_BUS_INITIATOR_WAIT_TIMEOUT_EN
  logic wd_expired;
  logic tmo_q, tmo_d;
  logic rsp_err_q, rsp_err_d;

  z80_bus_wait_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_in_tw   (state_q == ST_TW),
    .o_expired (wd_expired)
  );
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ta_cnt_d    = ta_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef Z80_BUS_INITIATOR_WAIT_TIMEOUT_EN
    tmo_d       = tmo_q;
    rsp_err_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_req_valid) begin
          cyc_d   = cyc_t'({bus.i_req_io, bus.i_req_wr});
          addr_d  = bus.i_req_addr;
          wdata_d = bus.i_req_wdata;
          state_d = ST_T1;
`ifdef Z80_BUS_INITIATOR_WAIT_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      ST_T1: state_d = ST_T2;
      ST_T2: begin
        if (cyc_is_io(cyc_q) && IO_AUTO_WAIT > 0) begin
          state_d  = ST_TA;
          ta_cnt_d = TA_LOAD;
        end else begin
          state_d = bus.i_wait ? ST_TW : ST_T3;
        end
      end
      ST_TA: begin
        if (ta_cnt_q == 2'd0) begin
          state_d = bus.i_wait ? ST_TW : ST_T3;
        end else begin
          ta_cnt_d = ta_cnt_q - 2'd1;
        end
      end
      ST_TW: begin
        if (!bus.i_wait) begin
          state_d = ST_T3;
        end
`ifdef Z80_BUS_INITIATOR_WAIT_TIMEOUT_EN
        else if (wd_expired) begin
          state_d = ST_T3;
          tmo_d   = 1'b1;
        end
`endif
      end
      ST_T3: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = cyc_is_wr(cyc_q) ? 8'h00 : bus.i_data;
`ifdef Z80_BUS_INITIATOR_WAIT_TIMEOUT_EN
        if (tmo_q) begin
          rsp_rdata_d = TIMEOUT_RDATA;
          rsp_err_d   = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cyc_q       <= MEM_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      ta_cnt_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ta_cnt_q    <= ta_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef Z80_BUS_INITIATOR_WAIT_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_q     <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign bus.o_rsp_err = rsp_err_q;
`else
  assign bus.o_rsp_err = 1'b0;
`endif

  logic        is_io, is_wr;
  logic        mreq_n, iorq_n, rd_n, wr_n, data_oe;
  logic [15:0] addr_out;
  logic [7:0]  data_out;

  assign is_io = cyc_is_io(cyc_q);
  assign is_wr = cyc_is_wr(cyc_q);

  // Strobes decode straight from the registered state; memory strobes lead I/O by one state.
  always_comb begin
    mreq_n   = 1'b1;
    iorq_n   = 1'b1;
    rd_n     = 1'b1;
    wr_n     = 1'b1;
    data_oe  = 1'b0;
    addr_out = 16'h0000;
    data_out = 8'h00;
    if (state_q != ST_IDLE) begin
      addr_out = addr_q;
      if (is_wr) begin
        data_oe  = 1'b1;
        data_out = wdata_q;
      end
      if (!is_io) begin
        if (state_q inside {ST_T1, ST_T2, ST_TW, ST_T3}) begin
          mreq_n = 1'b0;
          rd_n   = is_wr;
        end
        if (is_wr && state_q inside {ST_T2, ST_TW, ST_T3}) begin
          wr_n = 1'b0;
        end
      end else if (state_q inside {ST_T2, ST_TA, ST_TW, ST_T3}) begin
        iorq_n = 1'b0;
        rd_n   = is_wr;
        wr_n   = !is_wr;
      end
    end
  end

  assign bus.o_req_ready = (state_q == ST_IDLE);
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign bus.o_addr      = addr_out;
  assign bus.o_data      = data_out;
  assign bus.o_data_oe   = data_oe;
  assign bus.o_mreq_n    = mreq_n;
  assign bus.o_iorq_n    = iorq_n;
  assign bus.o_rd_n      = rd_n;
  assign bus.o_wr_n      = wr_n;
endmodule

// File: tb/tb_z80_bus_initiator.sv
// Scoreboard bench for z80_bus_initiator: directed bus cycles, strobe/latency checks.
module tb_z80_bus_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  z80_bus_initiator_if bus();

  z80_bus_initiator #(
    .IO_AUTO_WAIT   (1),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         mreq;
    int         iorq;
    int         rd;
    int         wr;
    int         oe;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(input logic [7:0] rdata, input logic err, input int lat,
                              input int mreq, input int iorq, input int rd, input int wr,
                              input int oe);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.mreq = mreq;
    e.iorq = iorq; e.rd = rd; e.wr = wr; e.oe = oe;
    return e;
  endfunction

  function automatic void chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d",
               nm, act, act, req, req, cyc);
    end
  endfunction

  // Monitor: measures each in-flight cycle and checks it against the queued expectation.
  bit          inflight = 1'b0;
  int          m_lat, m_mreq, m_iorq, m_rd, m_wr, m_oe, m_addr_bad, m_data_bad;
  logic [15:0] m_addr;
  logic [7:0]  m_wd;

  always @(negedge clk) begin
    if (rst) begin
      inflight = 1'b0;
    end else begin
      if (inflight) begin
        m_lat++;
        if (!bus.o_mreq_n) m_mreq++;
        if (!bus.o_iorq_n) m_iorq++;
        if (!bus.o_rd_n)   m_rd++;
        if (!bus.o_wr_n)   m_wr++;
        if (bus.o_data_oe) begin
          m_oe++;
          if (bus.o_data != m_wd) m_data_bad++;
        end
        if ((!bus.o_mreq_n || !bus.o_iorq_n) && bus.o_addr != m_addr) m_addr_bad++;
      end
      if (bus.o_rsp_valid) begin
        chk("rsp_expected", int'(exp_q.size() > 0 && inflight), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", int'(bus.o_rsp_rdata), int'(e.rdata));
          chk("rsp_err",   int'(bus.o_rsp_err), int'(e.err));
          chk("latency",   m_lat,  e.lat);
          chk("mreq_low",  m_mreq, e.mreq);
          chk("iorq_low",  m_iorq, e.iorq);
          chk("rd_low",    m_rd,   e.rd);
          chk("wr_low",    m_wr,   e.wr);
          chk("data_oe",   m_oe,   e.oe);
          chk("addr_hold", m_addr_bad, 0);
          chk("data_hold", m_data_bad, 0);
        end
        inflight = 1'b0;
      end
      if (bus.i_req_valid && bus.o_req_ready) begin
        inflight = 1'b1;
        m_lat = 0; m_mreq = 0; m_iorq = 0; m_rd = 0; m_wr = 0; m_oe = 0;
        m_addr_bad = 0; m_data_bad = 0;
        m_addr = bus.i_req_addr;
        m_wd   = bus.i_req_wdata;
      end
    end
  end

  task automatic issue(input logic wr, input logic io, input logic [15:0] a,
                       input logic [7:0] wd, input bit push, input exp_t e, output int acc);
    bit got;
    bus.i_req_valid = 1'b1;
    bus.i_req_wr    = wr;
    bus.i_req_io    = io;
    bus.i_req_addr  = a;
    bus.i_req_wdata = wd;
    if (push) exp_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.o_req_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("accept_in_time", int'(got), 1);
    acc = cyc;
  endtask

  // Drop valid and scramble request fields; the cycle in flight must not notice.
  task automatic release_req();
    bus.i_req_valid = 1'b0;
    bus.i_req_wr    = ~bus.i_req_wr;
    bus.i_req_io    = ~bus.i_req_io;
    bus.i_req_addr  = 16'hFFFF;
    bus.i_req_wdata = 8'hEE;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !inflight) break;
      @(posedge clk);
      #1;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int acc_a, acc_b, dummy;
    bus.i_req_valid = 1'b0;
    bus.i_req_wr    = 1'b0;
    bus.i_req_io    = 1'b0;
    bus.i_req_addr  = 16'h0000;
    bus.i_req_wdata = 8'h00;
    bus.i_wait      = 1'b0;
    bus.i_data      = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_ready",     int'(bus.o_req_ready), 1);
    chk("rst_mreq_n",    int'(bus.o_mreq_n), 1);
    chk("rst_iorq_n",    int'(bus.o_iorq_n), 1);
    chk("rst_rd_n",      int'(bus.o_rd_n), 1);
    chk("rst_wr_n",      int'(bus.o_wr_n), 1);
    chk("rst_addr",      int'(bus.o_addr), 0);
    chk("rst_data",      int'(bus.o_data), 0);
    chk("rst_data_oe",   int'(bus.o_data_oe), 0);
    chk("rst_rsp_valid", int'(bus.o_rsp_valid), 0);
    chk("rst_rsp_rdata", int'(bus.o_rsp_rdata), 0);
    chk("rst_rsp_err",   int'(bus.o_rsp_err), 0);

    // memory read, zero wait
    bus.i_data = 8'hA5;
    issue(1'b0, 1'b0, 16'h1234, 8'h00, 1'b1, mk(8'hA5, 1'b0, 4, 3, 0, 3, 0, 0), dummy);
    release_req();
    drain();

    // memory write, zero wait
    issue(1'b1, 1'b0, 16'h8000, 8'h5A, 1'b1, mk(8'h00, 1'b0, 4, 3, 0, 0, 2, 3), dummy);
    release_req();
    drain();

    // I/O write: T1,T2,TA,T3
    issue(1'b1, 1'b1, 16'h00C0, 8'h03, 1'b1, mk(8'h00, 1'b0, 5, 0, 3, 0, 3, 4), dummy);
    release_req();
    drain();

    // I/O read
    bus.i_data = 8'h3C;
    issue(1'b0, 1'b1, 16'h0040, 8'h00, 1'b1, mk(8'h3C, 1'b0, 5, 0, 3, 3, 0, 0), dummy);
    release_req();
    drain();

    // I/O write, wait high at both sample points (and at ignored T1/T2) -> 2 TW
    issue(1'b1, 1'b1, 16'h0081, 8'h7E, 1'b1, mk(8'h00, 1'b0, 7, 0, 5, 0, 5, 6), dummy);
    release_req();
    bus.i_wait = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.i_wait = 1'b0;
    drain();

    // memory read with one TW
    bus.i_data = 8'h96;
    issue(1'b0, 1'b0, 16'h4321, 8'h00, 1'b1, mk(8'h96, 1'b0, 5, 4, 0, 4, 0, 0), dummy);
    release_req();
    bus.i_wait = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.i_wait = 1'b0;
    drain();

    // reset while in TW abandons the cycle with no response
    bus.i_wait = 1'b1;
    issue(1'b0, 1'b0, 16'h5555, 8'h00, 1'b0, mk(8'h00, 1'b0, 0, 0, 0, 0, 0, 0), dummy);
    release_req();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_wait = 1'b0;
    chk("abort_ready",     int'(bus.o_req_ready), 1);
    chk("abort_mreq_n",    int'(bus.o_mreq_n), 1);
    chk("abort_iorq_n",    int'(bus.o_iorq_n), 1);
    chk("abort_rd_n",      int'(bus.o_rd_n), 1);
    chk("abort_wr_n",      int'(bus.o_wr_n), 1);
    chk("abort_addr",      int'(bus.o_addr), 0);
    chk("abort_rsp_valid", int'(bus.o_rsp_valid), 0);
    repeat (4) @(posedge clk);
    #1;
    bus.i_data = 8'h69;
    issue(1'b0, 1'b0, 16'h5556, 8'h00, 1'b1, mk(8'h69, 1'b0, 4, 3, 0, 3, 0, 0), dummy);
    release_req();
    drain();

`ifdef Z80_BUS_INITIATOR_WAIT_TIMEOUT_EN
    // wait stuck high: 4 TW then forced T3 with error
    bus.i_data = 8'h12;
    bus.i_wait = 1'b1;
    issue(1'b0, 1'b0, 16'h6000, 8'h00, 1'b1, mk(8'hFF, 1'b1, 8, 7, 0, 7, 0, 0), dummy);
    release_req();
    drain();
    bus.i_wait = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`endif

    // two requests held valid back-to-back: second accepted in the response cycle
    bus.i_data = 8'h11;
    issue(1'b0, 1'b0, 16'h2000, 8'h00, 1'b1, mk(8'h11, 1'b0, 4, 3, 0, 3, 0, 0), acc_a);
    issue(1'b1, 1'b0, 16'h2001, 8'h22, 1'b1, mk(8'h00, 1'b0, 4, 3, 0, 0, 2, 3), acc_b);
    release_req();
    chk("b2b_accept_gap", acc_b - acc_a, 4);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
